// File: rtl/output_port_vc_flit_sender_pkg.sv
// Shared NoC definitions used by the output-port VC flit sender and its credit counter.
package output_port_vc_flit_sender_pkg;
   localparam int NOC_VC_NUM       = 4;
   localparam int NOC_VC_NUM_IDX_W = (NOC_VC_NUM > 1) ? $clog2(NOC_VC_NUM) : 1;
   localparam int NOC_VC_DEPTH     = 1;
   localparam int NOC_FLIT_W       = 64;

   typedef struct packed {
      logic [NOC_FLIT_W-1:0]       payload;
      logic [NOC_VC_NUM_IDX_W-1:0] vc_id;
      logic                        tail;
   } noc_flit_t;

   // Round-robin successor of index g among n requesters.
   function automatic int rr_next(input int g, input int n);
      return (g >= n - 1) ? 0 : g + 1;
   endfunction
endpackage

// File: rtl/output_port_vc_flit_sender_if.sv
// Per-VC flit/credit inputs and registered link outputs of the output-port flit sender.
interface output_port_vc_flit_sender_if
   import output_port_vc_flit_sender_pkg::*;
#(
   parameter int VC_NUM             = NOC_VC_NUM,
   parameter int VC_NUM_IDX_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   parameter int VC_DEPTH_COUNTER_W = $clog2(NOC_VC_DEPTH + 1),
   parameter int FLIT_W             = NOC_FLIT_W
) ();
   logic [VC_NUM-1:0]                    vc_flit_vld_i;
   logic [VC_NUM*FLIT_W-1:0]             vc_flit_i;
   logic [VC_NUM-1:0]                    vc_flit_tail_i;
   logic [VC_NUM-1:0]                    vc_flit_rdy_o;
   logic [VC_NUM*VC_DEPTH_COUNTER_W-1:0] vc_credit_counter_i;
   logic                                 consume_vc_credit_vld_o;
   logic [VC_NUM_IDX_W-1:0]              consume_vc_credit_vc_id_o;
   logic                                 tx_flit_vld_o;
   logic [FLIT_W-1:0]                    tx_flit_o;
   logic [VC_NUM_IDX_W-1:0]              tx_flit_vc_id_o;

   // master: the flit sender itself; slave: VC buffers, credit counter and link.
   modport master (
      input  vc_flit_vld_i, vc_flit_i, vc_flit_tail_i, vc_credit_counter_i,
      output vc_flit_rdy_o, consume_vc_credit_vld_o, consume_vc_credit_vc_id_o,
             tx_flit_vld_o, tx_flit_o, tx_flit_vc_id_o
   );

   modport slave (
      output vc_flit_vld_i, vc_flit_i, vc_flit_tail_i, vc_credit_counter_i,
      input  vc_flit_rdy_o, consume_vc_credit_vld_o, consume_vc_credit_vc_id_o,
             tx_flit_vld_o, tx_flit_o, tx_flit_vc_id_o
   );
endinterface

// File: rtl/output_port_vc_flit_sender_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (wrapping) wins, one-hot grant.
module output_port_vc_flit_sender_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);
   int   idx;
   logic found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IDX_W'(idx);
         end
      end
   end
endmodule

// File: rtl/output_port_vc_flit_sender.sv
// Selects one VC per cycle to send a flit on the output link, spending one downstream credit per flit.
module output_port_vc_flit_sender
   import output_port_vc_flit_sender_pkg::*;
#(
   parameter int VC_NUM             = NOC_VC_NUM,
   parameter int VC_NUM_IDX_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   parameter int VC_DEPTH           = NOC_VC_DEPTH,
   parameter int VC_DEPTH_COUNTER_W = $clog2(VC_DEPTH + 1),
   parameter int FLIT_W             = NOC_FLIT_W,
   parameter int PKT_LOCK           = 0
) (
   input logic                          clk,
   input logic                          rst,
   output_port_vc_flit_sender_if.master link
);
   logic [VC_NUM-1:0]       eligible_p0;
   logic [VC_NUM-1:0]       req_p0;
   logic [VC_NUM-1:0]       gnt_p0;
   logic [VC_NUM_IDX_W-1:0] gnt_idx_p0;
   logic                    gnt_vld_p0;
   logic [FLIT_W-1:0]       sel_flit_p0;
   logic [VC_NUM_IDX_W-1:0] rr_ptr;
   logic                    lock_vld;
   logic [VC_NUM_IDX_W-1:0] lock_vc;

   always_comb begin
      eligible_p0 = '0;
      for (int i = 0; i < VC_NUM; i++)
         eligible_p0[i] = link.vc_flit_vld_i[i] &
            (link.vc_credit_counter_i[i*VC_DEPTH_COUNTER_W +: VC_DEPTH_COUNTER_W] != '0);
   end

   always_comb begin
      req_p0 = eligible_p0;
      if (lock_vld)
         for (int i = 0; i < VC_NUM; i++)
            if (VC_NUM_IDX_W'(i) != lock_vc) req_p0[i] = 1'b0;
   end

   output_port_vc_flit_sender_rr_arbiter #(
      .N     (VC_NUM),
      .IDX_W (VC_NUM_IDX_W)
   ) u_rr_arbiter (
      .req     (req_p0),
      .ptr     (rr_ptr),
      .gnt     (gnt_p0),
      .gnt_idx (gnt_idx_p0)
   );

   assign gnt_vld_p0 = |gnt_p0;

   always_comb begin
      sel_flit_p0 = '0;
      for (int i = 0; i < VC_NUM; i++)
         if (gnt_p0[i]) sel_flit_p0 = link.vc_flit_i[i*FLIT_W +: FLIT_W];
   end

   // Pop and credit consume happen in the grant cycle; the counter reflects it one cycle later.
   assign link.vc_flit_rdy_o            = gnt_p0;
   assign link.consume_vc_credit_vld_o   = gnt_vld_p0;
   assign link.consume_vc_credit_vc_id_o = gnt_idx_p0;

   // ---- p0 -> p1: registered link output and round-robin pointer ----
   always_ff @(posedge clk) begin
      if (rst) begin
         link.tx_flit_vld_o   <= 1'b0;
         link.tx_flit_o       <= '0;
         link.tx_flit_vc_id_o <= '0;
         rr_ptr               <= '0;
      end else begin
         link.tx_flit_vld_o <= gnt_vld_p0;
         if (gnt_vld_p0) begin
            link.tx_flit_o       <= sel_flit_p0;
            link.tx_flit_vc_id_o <= gnt_idx_p0;
            rr_ptr               <= VC_NUM_IDX_W'(rr_next(int'(gnt_idx_p0), VC_NUM));
         end
      end
   end

   generate
      if (PKT_LOCK != 0) begin : g_lock
         logic tail_sel_p0;

         always_comb begin
            tail_sel_p0 = 1'b0;
            for (int i = 0; i < VC_NUM; i++)
               if (gnt_p0[i]) tail_sel_p0 = link.vc_flit_tail_i[i];
         end

         // A non-tail grant pins the link to that VC until its tail goes out.
         always_ff @(posedge clk) begin
            if (rst) begin
               lock_vld <= 1'b0;
               lock_vc  <= '0;
            end else if (gnt_vld_p0) begin
               lock_vld <= ~tail_sel_p0;
               if (!tail_sel_p0) lock_vc <= gnt_idx_p0;
            end
         end
      end else begin : g_no_lock
         assign lock_vld = 1'b0;
         assign lock_vc  = '0;
      end
   endgenerate
endmodule

// File: tb/tb_output_port_vc_flit_sender.sv
// Directed bench for the output-port VC flit sender with a small credit-counter model in the loop.
module tb_output_port_vc_flit_sender;
   localparam int VN = 4;
   localparam int IW = 2;
   localparam int CW = 2;
   localparam int FW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   output_port_vc_flit_sender_if #(
      .VC_NUM(VN), .VC_NUM_IDX_W(IW), .VC_DEPTH_COUNTER_W(CW), .FLIT_W(FW)
   ) bus ();

   output_port_vc_flit_sender #(
      .VC_NUM(VN), .VC_NUM_IDX_W(IW), .VC_DEPTH(2), .VC_DEPTH_COUNTER_W(CW),
      .FLIT_W(FW), .PKT_LOCK(1)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .link (bus)
   );

   // Downstream credit counter stand-in: reset to full (2), load override, free/consume net.
   logic [CW-1:0] credit [VN];
   logic [CW-1:0] load_val [VN];
   logic [VN-1:0] free;
   logic          load_en;

   always @(posedge clk) begin
      for (int i = 0; i < VN; i++) begin
         if (rst) credit[i] <= CW'(2);
         else if (load_en) credit[i] <= load_val[i];
         else credit[i] <= credit[i]
            - CW'(bus.consume_vc_credit_vld_o && (bus.consume_vc_credit_vc_id_o == IW'(i)))
            + CW'(free[i]);
      end
   end

   always_comb begin
      bus.vc_credit_counter_i = '0;
      for (int i = 0; i < VN; i++) bus.vc_credit_counter_i[i*CW +: CW] = credit[i];
   end

   task automatic set_flit(input int vc, input logic [FW-1:0] v);
      bus.vc_flit_i[vc*FW +: FW] = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.vc_flit_vld_i  = '0;
      bus.vc_flit_tail_i = '1;
      bus.vc_flit_i      = '0;
      free    = '0;
      load_en = 1'b0;
      for (int i = 0; i < VN; i++) load_val[i] = CW'(2);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      if (bus.tx_flit_vld_o !== 1'b0) begin errors++; $display("FAIL reset_tx_vld: got %b want 0", bus.tx_flit_vld_o); end
      checks++;
      if (bus.tx_flit_o !== 16'h0) begin errors++; $display("FAIL reset_tx_flit: got %h want 0000", bus.tx_flit_o); end
      checks++;
      if (bus.tx_flit_vc_id_o !== 2'd0) begin errors++; $display("FAIL reset_tx_id: got %0d want 0", bus.tx_flit_vc_id_o); end
      checks++;
      if (bus.vc_flit_rdy_o !== 4'b0000) begin errors++; $display("FAIL reset_rdy: got %b want 0000", bus.vc_flit_rdy_o); end
      checks++;
      if (bus.consume_vc_credit_vld_o !== 1'b0 || bus.consume_vc_credit_vc_id_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_consume: got vld=%b id=%0d want vld=0 id=0",
                  bus.consume_vc_credit_vld_o, bus.consume_vc_credit_vc_id_o);
      end
      checks++;
      @(negedge clk);
   endtask

   task automatic test_credit_stall();
      do_reset();
      bus.vc_flit_vld_i = 4'b0001;
      set_flit(0, 16'h1001);
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0001 || bus.consume_vc_credit_vld_o !== 1'b1 || bus.consume_vc_credit_vc_id_o !== 2'd0) begin
         errors++;
         $display("FAIL stall_grant1: got rdy=%b cvld=%b cid=%0d want rdy=0001 cvld=1 cid=0",
                  bus.vc_flit_rdy_o, bus.consume_vc_credit_vld_o, bus.consume_vc_credit_vc_id_o);
      end
      checks++;
      @(negedge clk);
      set_flit(0, 16'h1002);
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0001 || bus.consume_vc_credit_vc_id_o !== 2'd0) begin
         errors++; $display("FAIL stall_grant2: got rdy=%b cid=%0d want rdy=0001 cid=0", bus.vc_flit_rdy_o, bus.consume_vc_credit_vc_id_o);
      end
      checks++;
      if (bus.tx_flit_vld_o !== 1'b1 || bus.tx_flit_o !== 16'h1001 || bus.tx_flit_vc_id_o !== 2'd0) begin
         errors++;
         $display("FAIL stall_tx1: got vld=%b flit=%h id=%0d want vld=1 flit=1001 id=0",
                  bus.tx_flit_vld_o, bus.tx_flit_o, bus.tx_flit_vc_id_o);
      end
      checks++;
      @(negedge clk);
      set_flit(0, 16'h1003);
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0000 || bus.consume_vc_credit_vld_o !== 1'b0) begin
         errors++; $display("FAIL stall_no_credit: got rdy=%b cvld=%b want rdy=0000 cvld=0", bus.vc_flit_rdy_o, bus.consume_vc_credit_vld_o);
      end
      checks++;
      if (bus.tx_flit_o !== 16'h1002) begin errors++; $display("FAIL stall_tx2: got %h want 1002", bus.tx_flit_o); end
      checks++;
      free = 4'b0001;
      @(negedge clk);
      free = 4'b0000;
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0001) begin errors++; $display("FAIL stall_regrant: got rdy=%b want 0001", bus.vc_flit_rdy_o); end
      checks++;
      if (bus.tx_flit_vld_o !== 1'b0 || bus.tx_flit_o !== 16'h1002) begin
         errors++; $display("FAIL stall_tx_hold: got vld=%b flit=%h want vld=0 flit=1002", bus.tx_flit_vld_o, bus.tx_flit_o);
      end
      checks++;
      @(negedge clk);
      bus.vc_flit_vld_i = 4'b0000;
      #1;
      if (bus.tx_flit_vld_o !== 1'b1 || bus.tx_flit_o !== 16'h1003) begin
         errors++; $display("FAIL stall_tx3: got vld=%b flit=%h want vld=1 flit=1003", bus.tx_flit_vld_o, bus.tx_flit_o);
      end
      checks++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_rdy;
      logic [1:0] exp_id;
      do_reset();
      bus.vc_flit_vld_i = 4'b1111;
      for (int v = 0; v < VN; v++) set_flit(v, 16'h2000 + 16'(v));
      for (int k = 0; k < 5; k++) begin
         #1;
         exp_rdy = 4'b0001 << (k % 4);
         if (bus.vc_flit_rdy_o !== exp_rdy) begin
            errors++; $display("FAIL b2b_grant%0d: got rdy=%b want %b", k, bus.vc_flit_rdy_o, exp_rdy);
         end
         checks++;
         if (k > 0) begin
            exp_id = 2'((k - 1) % 4);
            if (bus.tx_flit_vld_o !== 1'b1 || bus.tx_flit_vc_id_o !== exp_id || bus.tx_flit_o !== (16'h2000 + 16'(exp_id))) begin
               errors++;
               $display("FAIL b2b_tx%0d: got vld=%b id=%0d flit=%h want vld=1 id=%0d flit=%h",
                        k, bus.tx_flit_vld_o, bus.tx_flit_vc_id_o, bus.tx_flit_o, exp_id, 16'h2000 + 16'(exp_id));
            end
            checks++;
         end
         @(negedge clk);
      end
      bus.vc_flit_vld_i = 4'b0000;
      #1;
      if (bus.tx_flit_vld_o !== 1'b1 || bus.tx_flit_vc_id_o !== 2'd0) begin
         errors++; $display("FAIL b2b_tx_last: got vld=%b id=%0d want vld=1 id=0", bus.tx_flit_vld_o, bus.tx_flit_vc_id_o);
      end
      checks++;
      @(negedge clk);
   endtask

   task automatic test_skip_zero_credit();
      do_reset();
      bus.vc_flit_vld_i = 4'b0001;
      load_en = 1'b1;
      load_val[0] = 2'd2; load_val[1] = 2'd0; load_val[2] = 2'd2; load_val[3] = 2'd2;
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0001) begin errors++; $display("FAIL skip_setup: got rdy=%b want 0001", bus.vc_flit_rdy_o); end
      checks++;
      @(negedge clk);
      load_en = 1'b0;
      bus.vc_flit_vld_i = 4'b0111;
      for (int v = 0; v < VN; v++) set_flit(v, 16'h3000 + 16'(v));
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0100 || bus.consume_vc_credit_vc_id_o !== 2'd2) begin
         errors++; $display("FAIL skip_vc1: got rdy=%b cid=%0d want rdy=0100 cid=2", bus.vc_flit_rdy_o, bus.consume_vc_credit_vc_id_o);
      end
      checks++;
      @(negedge clk);
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0001) begin errors++; $display("FAIL skip_ptr3: got rdy=%b want 0001", bus.vc_flit_rdy_o); end
      checks++;
      if (bus.tx_flit_vc_id_o !== 2'd2 || bus.tx_flit_o !== 16'h3002) begin
         errors++; $display("FAIL skip_tx: got id=%0d flit=%h want id=2 flit=3002", bus.tx_flit_vc_id_o, bus.tx_flit_o);
      end
      checks++;
      @(negedge clk);
      bus.vc_flit_vld_i = 4'b0000;
   endtask

   task automatic test_pkt_lock();
      do_reset();
      load_en = 1'b1;
      load_val[0] = 2'd1;
      @(negedge clk);
      load_en = 1'b0;
      bus.vc_flit_vld_i  = 4'b1001;
      bus.vc_flit_tail_i = 4'b1000;
      set_flit(0, 16'h4001);
      set_flit(3, 16'h4300);
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0001) begin errors++; $display("FAIL lock_head: got rdy=%b want 0001", bus.vc_flit_rdy_o); end
      checks++;
      @(negedge clk);
      set_flit(0, 16'h4002);
      bus.vc_flit_tail_i = 4'b1001;
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0000 || bus.consume_vc_credit_vld_o !== 1'b0) begin
         errors++; $display("FAIL lock_block_vc3: got rdy=%b cvld=%b want rdy=0000 cvld=0", bus.vc_flit_rdy_o, bus.consume_vc_credit_vld_o);
      end
      checks++;
      @(negedge clk);
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0000 || bus.tx_flit_vld_o !== 1'b0) begin
         errors++; $display("FAIL lock_hold: got rdy=%b txvld=%b want rdy=0000 txvld=0", bus.vc_flit_rdy_o, bus.tx_flit_vld_o);
      end
      checks++;
      free = 4'b0001;
      @(negedge clk);
      free = 4'b0000;
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0001) begin errors++; $display("FAIL lock_tail: got rdy=%b want 0001", bus.vc_flit_rdy_o); end
      checks++;
      @(negedge clk);
      bus.vc_flit_vld_i = 4'b1000;
      #1;
      if (bus.vc_flit_rdy_o !== 4'b1000) begin errors++; $display("FAIL lock_release: got rdy=%b want 1000", bus.vc_flit_rdy_o); end
      checks++;
      if (bus.tx_flit_o !== 16'h4002 || bus.tx_flit_vc_id_o !== 2'd0) begin
         errors++; $display("FAIL lock_tx_tail: got flit=%h id=%0d want flit=4002 id=0", bus.tx_flit_o, bus.tx_flit_vc_id_o);
      end
      checks++;
      @(negedge clk);
      bus.vc_flit_vld_i = 4'b0000;
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      bus.vc_flit_vld_i  = 4'b0010;
      bus.vc_flit_tail_i = 4'b1101;
      set_flit(1, 16'h5001);
      #1;
      if (bus.vc_flit_rdy_o !== 4'b0010) begin errors++; $display("FAIL midrst_head: got rdy=%b want 0010", bus.vc_flit_rdy_o); end
      checks++;
      @(negedge clk);
      rst = 1'b1;
      bus.vc_flit_vld_i  = 4'b1000;
      bus.vc_flit_tail_i = 4'b1111;
      #1;
      if (bus.tx_flit_vld_o !== 1'b1 || bus.vc_flit_rdy_o !== 4'b0000) begin
         errors++; $display("FAIL midrst_pre: got txvld=%b rdy=%b want txvld=1 rdy=0000", bus.tx_flit_vld_o, bus.vc_flit_rdy_o);
      end
      checks++;
      @(negedge clk);
      rst = 1'b0;
      bus.vc_flit_vld_i = 4'b1001;
      #1;
      if (bus.tx_flit_vld_o !== 1'b0 || bus.tx_flit_o !== 16'h0 || bus.tx_flit_vc_id_o !== 2'd0) begin
         errors++;
         $display("FAIL midrst_tx: got vld=%b flit=%h id=%0d want vld=0 flit=0000 id=0",
                  bus.tx_flit_vld_o, bus.tx_flit_o, bus.tx_flit_vc_id_o);
      end
      checks++;
      if (bus.vc_flit_rdy_o !== 4'b0001) begin errors++; $display("FAIL midrst_unlock_ptr: got rdy=%b want 0001", bus.vc_flit_rdy_o); end
      checks++;
      @(negedge clk);
      bus.vc_flit_vld_i = 4'b0000;
   endtask

   task automatic test_free_consume_same();
      do_reset();
      load_en = 1'b1;
      load_val[0] = 2'd1;
      @(negedge clk);
      load_en = 1'b0;
      bus.vc_flit_vld_i = 4'b0001;
      free = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         set_flit(0, 16'h6000 + 16'(k));
         #1;
         if (bus.vc_flit_rdy_o !== 4'b0001) begin errors++; $display("FAIL same_grant%0d: got rdy=%b want 0001", k, bus.vc_flit_rdy_o); end
         checks++;
         if (k > 0 && (bus.tx_flit_vld_o !== 1'b1 || bus.tx_flit_o !== (16'h6000 + 16'(k - 1)))) begin
            errors++;
            $display("FAIL same_tx%0d: got vld=%b flit=%h want vld=1 flit=%h", k, bus.tx_flit_vld_o, bus.tx_flit_o, 16'h6000 + 16'(k - 1));
         end
         if (k > 0) checks++;
         @(negedge clk);
      end
      free = 4'b0000;
      bus.vc_flit_vld_i = 4'b0000;
   endtask

   initial begin
      rst = 1'b1;
      bus.vc_flit_vld_i  = '0;
      bus.vc_flit_tail_i = '1;
      bus.vc_flit_i      = '0;
      free    = '0;
      load_en = 1'b0;
      for (int i = 0; i < VN; i++) load_val[i] = CW'(2);
      do_reset();
      test_reset();
      test_credit_stall();
      test_back_to_back();
      test_skip_zero_credit();
      test_pkt_lock();
      test_reset_mid_packet();
      test_free_consume_same();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
